// File: rtl/rv4028_bus_ctrl.sv
// Bus sequencer/arbiter between the FemtoRV core and the RV4028 16-bit bus.
// Optional wait-state timeout is built only when BUS_WAIT_TIMEOUT_EN is defined.
//
// state  | meaning
// S_IDLE | no bus cycle; accept core request or grant the bus
// S_T1   | address phase, mreq_n asserted in the low phase
// S_T2   | strobe phase, wait_n sampled
// S_TW   | wait state, wait_n sampled each cycle
// S_T3   | final strobe cycle, read data captured at its end
// S_HOLD | bus granted to the external master
module rv4028_bus_ctrl #(
  parameter int WAIT_LIMIT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wmask,
  input  logic        mem_rstrb,
  output logic [31:0] mem_rdata,
  output logic        mem_rbusy,
  output logic        mem_wbusy,
  output logic [31:0] addr,
  output logic [15:0] data_out,
  output logic        data_oe,
  input  logic [15:0] data_in,
  output logic        rd_n,
  output logic [1:0]  msk_n,
  output logic [1:0]  mreq_n,
  output logic [1:0]  wr_n,
  input  logic        wait_n,
  input  logic        busrq_n,
  output logic        busack_n,
  output logic        bus_oe,
  output logic        bus_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_T1,
    S_T2,
    S_TW,
    S_T3,
    S_HOLD
  } state_t;

  state_t      state_q, state_d;
  logic [29:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wmask_q, wmask_d;
  logic        wr_q, wr_d;
  logic        half_q, half_d;
  logic        busy_q, busy_d;
  logic [31:0] rdata_q, rdata_d;

  logic        req_wr;
  logic        take_req;
  logic        last_half;
  logic        in_cyc;
  logic        strobe_ph;
  logic [1:0]  mask_slice;
  logic [15:0] cap_data;
  logic        unused_ok;

`ifdef BUS_WAIT_TIMEOUT_EN
  localparam logic [7:0] WCNT_LOAD = 8'(WAIT_LIMIT - 1);

  logic [7:0] wcnt_q, wcnt_d;
  logic       to_q, to_d;
  logic       err_q, err_d;

  assign cap_data  = to_q ? 16'hFFFF : data_in;
  assign bus_err   = err_q;
  assign unused_ok = ^mem_addr[1:0];
`else
  assign cap_data  = data_in;
  assign bus_err   = 1'b0;
  assign unused_ok = ^mem_addr[1:0] ^ (WAIT_LIMIT != 0);
`endif

  assign req_wr     = |mem_wmask;
  // A request is latched only while nothing is outstanding; one may be parked during HOLD.
  assign take_req   = !busy_q && (req_wr || mem_rstrb) &&
                      (state_q == S_IDLE || state_q == S_HOLD);
  assign mask_slice = half_q ? wmask_q[3:2] : wmask_q[1:0];
  assign last_half  = half_q || (wr_q && (wmask_q[3:2] == 2'b00));

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wmask_d = wmask_q;
    wr_d    = wr_q;
    half_d  = half_q;
    busy_d  = busy_q;
    rdata_d = rdata_q;
`ifdef BUS_WAIT_TIMEOUT_EN
    wcnt_d  = wcnt_q;
    to_d    = to_q;
    err_d   = err_q;
`endif

    if (take_req) begin
      busy_d  = 1'b1;
      wr_d    = req_wr;
      wmask_d = req_wr ? mem_wmask : 4'b0000;
      wdata_d = mem_wdata;
      addr_d  = mem_addr[31:2];
    end

    case (state_q)
      S_IDLE: begin
        if (!busrq_n) begin
          state_d = S_HOLD;
        end else if (take_req) begin
          state_d = S_T1;
          half_d  = req_wr && (mem_wmask[1:0] == 2'b00);
        end else if (busy_q) begin
          state_d = S_T1;
          half_d  = wr_q && (wmask_q[1:0] == 2'b00);
        end
      end
      S_HOLD: begin
        if (busrq_n) state_d = S_IDLE;
      end
      S_T1: begin
        state_d = S_T2;
`ifdef BUS_WAIT_TIMEOUT_EN
        to_d    = 1'b0;
`endif
      end
      S_T2: begin
        if (!wait_n) begin
          state_d = S_TW;
`ifdef BUS_WAIT_TIMEOUT_EN
          wcnt_d  = WCNT_LOAD;
`endif
        end else begin
          state_d = S_T3;
        end
      end
      S_TW: begin
        if (wait_n) begin
          state_d = S_T3;
        end
`ifdef BUS_WAIT_TIMEOUT_EN
        else if (wcnt_q == 8'd0) begin
          state_d = S_T3;
          to_d    = 1'b1;
          err_d   = 1'b1;
        end else begin
          wcnt_d  = wcnt_q - 8'd1;
        end
`endif
      end
      S_T3: begin
        if (!wr_q) begin
          if (half_q) rdata_d[31:16] = cap_data;
          else        rdata_d[15:0]  = cap_data;
        end
        if (last_half) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end else begin
          state_d = S_T1;
          half_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      wmask_q <= '0;
      wr_q    <= 1'b0;
      half_q  <= 1'b0;
      busy_q  <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wmask_q <= wmask_d;
      wr_q    <= wr_d;
      half_q  <= half_d;
      busy_q  <= busy_d;
      rdata_q <= rdata_d;
    end
  end

`ifdef BUS_WAIT_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wcnt_q <= '0;
      to_q   <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      wcnt_q <= wcnt_d;
      to_q   <= to_d;
      err_q  <= err_d;
    end
  end
`endif

  assign in_cyc    = (state_q == S_T1) || (state_q == S_T2) ||
                     (state_q == S_TW) || (state_q == S_T3);
  assign strobe_ph = (state_q == S_T2) || (state_q == S_TW) || (state_q == S_T3);

  // DDR codes: bit 0 drives the high phase, bit 1 the following low phase.
  always_comb begin
    mreq_n = 2'b11;
    wr_n   = 2'b11;
    if (state_q == S_T1) mreq_n = 2'b01;
    else if (strobe_ph)  mreq_n = 2'b00;
    if (wr_q && state_q == S_T2)                          wr_n = 2'b01;
    else if (wr_q && (state_q == S_TW || state_q == S_T3)) wr_n = 2'b00;
  end

  assign rd_n      = !(strobe_ph && !wr_q);
  assign data_oe   = in_cyc && wr_q;
  assign msk_n     = !in_cyc ? 2'b11 : (wr_q ? ~mask_slice : 2'b00);
  assign addr      = {addr_q, half_q, 1'b0};
  assign data_out  = half_q ? wdata_q[31:16] : wdata_q[15:0];
  assign busack_n  = (state_q != S_HOLD);
  assign bus_oe    = (state_q != S_HOLD);
  assign mem_rdata = rdata_q;
  assign mem_rbusy = busy_q && !wr_q;
  assign mem_wbusy = busy_q && wr_q;

endmodule
